mem_controller: RTL

Single-port arbiter between the 8-bit external RAM bus and the two memory clients: the instruction fetcher and the load/store buffer. It serves the fetcher's one-cycle fetch pulses by assembling a 32-bit little-endian instruction over four byte reads. It also serves 1/2/4-byte loads and stores from the load/store buffer. It owns the `mem_a`/`mem_dout`/`mem_wr` pins and discards speculative work on ROB roll back.

---
 rtl/mem_controller_if.sv | 41 ++++
 rtl/mem_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_controller_if.sv
// Bus bundle for mem_controller: the byte-wide RAM pins, the fetcher and
// load/store-buffer request/response lines, and the ROB flush line.
interface mem_controller_if;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        IF_need_fetch;
  logic [31:0] IF_fetch_pc;
  logic        IF_output_valid;
  logic [31:0] IF_inst;
  logic        LSB_need_load;
  logic        LSB_need_store;
  logic [31:0] LSB_addr;
  logic [1:0]  LSB_size;
  logic [31:0] LSB_store_data;
  logic        LSB_output_valid;
  logic [31:0] LSB_load_data;
  logic        ROB_roll_back_flag;

  modport slave (
    input  mem_din, io_buffer_full,
    input  IF_need_fetch, IF_fetch_pc,
    input  LSB_need_load, LSB_need_store, LSB_addr, LSB_size, LSB_store_data,
    input  ROB_roll_back_flag,
    output mem_dout, mem_a, mem_wr,
    output IF_output_valid, IF_inst,
    output LSB_output_valid, LSB_load_data
  );

  modport master (
    output mem_din, io_buffer_full,
    output IF_need_fetch, IF_fetch_pc,
    output LSB_need_load, LSB_need_store, LSB_addr, LSB_size, LSB_store_data,
    output ROB_roll_back_flag,
    input  mem_dout, mem_a, mem_wr,
    input  IF_output_valid, IF_inst,
    input  LSB_output_valid, LSB_load_data
  );
endinterface

// File: rtl/mem_controller.sv
// Arbiter between the byte-wide RAM bus, the instruction fetcher and the
// load/store buffer; assembles little-endian words one byte per cycle.
module mem_controller (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  mem_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    STORE = 2'd3
  } state_t;

  function automatic logic [2:0] last_index(input logic [1:0] size);
    case (size)
      2'd0:    last_index = 3'd0;
      2'd1:    last_index = 3'd1;
      default: last_index = 3'd3;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] data, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_of = data[7:0];
      2'd1:    byte_of = data[15:8];
      2'd2:    byte_of = data[23:16];
      default: byte_of = data[31:24];
    endcase
  endfunction

  function automatic logic [31:0] zero_ext(input logic [31:0] data, input logic [1:0] size);
    case (size)
      2'd0:    zero_ext = {24'd0, data[7:0]};
      2'd1:    zero_ext = {16'd0, data[15:0]};
      default: zero_ext = data;
    endcase
  endfunction

  state_t      state_r;
  logic [2:0]  cnt_r;
  logic        if_pend_r;
  logic [31:0] if_addr_r;
  logic        ls_pend_r;
  logic        ls_is_store_r;
  logic [31:0] ls_addr_r;
  logic [1:0]  ls_size_r;
  logic [31:0] ls_data_r;
  logic [31:0] asm_r;
  logic        resume_r;
  logic [7:0]  mem_dout_r;
  logic [31:0] mem_a_r;
  logic        mem_wr_r;
  logic        if_valid_r;
  logic [31:0] if_inst_r;
  logic        lsb_valid_r;
  logic [31:0] lsb_data_r;

  logic        roll_s;
  logic        if_pulse_s;
  logic        ls_pulse_s;
  logic        sel_store_s;
  logic [31:0] sel_ls_addr_s;
  logic [1:0]  sel_size_s;
  logic [31:0] sel_data_s;
  logic [31:0] sel_if_addr_s;
  logic        ls_avail_s;
  logic        if_avail_s;
  logic        ls_blocked_s;
  logic        start_ls_s;
  logic        start_if_s;
  logic [2:0]  last_s;
  logic [31:0] asm_next_s;

  // Request selection: a same-edge pulse wins over the latched copy; flush drops pulses and pending loads.
  always_comb begin
    roll_s     = bus.ROB_roll_back_flag;
    if_pulse_s = bus.IF_need_fetch & ~roll_s;
    ls_pulse_s = (bus.LSB_need_load | bus.LSB_need_store) & ~roll_s;

    if (ls_pulse_s) begin
      sel_store_s   = bus.LSB_need_store;
      sel_ls_addr_s = bus.LSB_addr;
      sel_size_s    = bus.LSB_size;
      sel_data_s    = bus.LSB_store_data;
    end else begin
      sel_store_s   = ls_is_store_r;
      sel_ls_addr_s = ls_addr_r;
      sel_size_s    = ls_size_r;
      sel_data_s    = ls_data_r;
    end

    if (if_pulse_s) begin
      sel_if_addr_s = bus.IF_fetch_pc;
    end else begin
      sel_if_addr_s = if_addr_r;
    end

    ls_avail_s   = ls_pulse_s | (ls_pend_r & ~(roll_s & ~ls_is_store_r));
    if_avail_s   = if_pulse_s | (if_pend_r & ~roll_s);
    // A stalled IO store still counts as available so the fetch cannot overtake it.
    ls_blocked_s = sel_store_s & (sel_ls_addr_s[17:16] == 2'b11) & bus.io_buffer_full;
    start_ls_s   = (state_r == IDLE) & ls_avail_s & ~ls_blocked_s;
    start_if_s   = (state_r == IDLE) & ~ls_avail_s & if_avail_s;
  end

  // Last byte index of the running transfer and the assembly word with the current lane filled.
  always_comb begin
    if (state_r == FETCH) begin
      last_s = 3'd3;
    end else begin
      last_s = last_index(ls_size_r);
    end

    asm_next_s = asm_r;
    case (cnt_r[1:0])
      2'd0:    asm_next_s[7:0]   = bus.mem_din;
      2'd1:    asm_next_s[15:8]  = bus.mem_din;
      2'd2:    asm_next_s[23:16] = bus.mem_din;
      default: asm_next_s[31:24] = bus.mem_din;
    endcase
  end

  // Pending request registers, transfer FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= 3'd0;
      if_pend_r     <= 1'b0;
      if_addr_r     <= 32'd0;
      ls_pend_r     <= 1'b0;
      ls_is_store_r <= 1'b0;
      ls_addr_r     <= 32'd0;
      ls_size_r     <= 2'd0;
      ls_data_r     <= 32'd0;
      asm_r         <= 32'd0;
      resume_r      <= 1'b0;
      mem_dout_r    <= 8'd0;
      mem_a_r       <= 32'd0;
      mem_wr_r      <= 1'b0;
      if_valid_r    <= 1'b0;
      if_inst_r     <= 32'd0;
      lsb_valid_r   <= 1'b0;
      lsb_data_r    <= 32'd0;
    end else if (!rdy) begin
      // The RAM may not take the byte while stalled; STORE rewrites it on resume.
      mem_wr_r <= 1'b0;
      resume_r <= (state_r == STORE);
    end else begin
      if_valid_r  <= 1'b0;
      lsb_valid_r <= 1'b0;
      resume_r    <= 1'b0;

      if (if_pulse_s) begin
        if_addr_r <= bus.IF_fetch_pc;
      end
      if (start_if_s || roll_s) begin
        if_pend_r <= 1'b0;
      end else if (if_pulse_s) begin
        if_pend_r <= 1'b1;
      end

      if (ls_pulse_s) begin
        ls_is_store_r <= bus.LSB_need_store;
        ls_addr_r     <= bus.LSB_addr;
        ls_size_r     <= bus.LSB_size;
        ls_data_r     <= bus.LSB_store_data;
      end
      if (start_ls_s) begin
        ls_pend_r <= 1'b0;
      end else if (ls_pulse_s) begin
        ls_pend_r <= 1'b1;
      end else if (roll_s && !ls_is_store_r) begin
        ls_pend_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (start_ls_s) begin
            mem_a_r <= sel_ls_addr_s;
            cnt_r   <= 3'd0;
            if (sel_store_s) begin
              state_r    <= STORE;
              mem_wr_r   <= 1'b1;
              mem_dout_r <= byte_of(sel_data_s, 2'd0);
            end else begin
              state_r <= LOAD;
            end
          end else if (start_if_s) begin
            mem_a_r <= sel_if_addr_s;
            cnt_r   <= 3'd0;
            state_r <= FETCH;
          end
        end
        FETCH, LOAD: begin
          if (roll_s) begin
            state_r <= IDLE;
            mem_a_r <= 32'd0;
            cnt_r   <= 3'd0;
          end else begin
            asm_r <= asm_next_s;
            if (cnt_r == last_s) begin
              state_r <= IDLE;
              mem_a_r <= 32'd0;
              cnt_r   <= 3'd0;
              if (state_r == FETCH) begin
                if_valid_r <= 1'b1;
                if_inst_r  <= asm_next_s;
              end else begin
                lsb_valid_r <= 1'b1;
                lsb_data_r  <= zero_ext(asm_next_s, ls_size_r);
              end
            end else begin
              mem_a_r <= mem_a_r + 32'd1;
              cnt_r   <= cnt_r + 3'd1;
            end
          end
        end
        STORE: begin
          if (resume_r) begin
            mem_wr_r <= 1'b1;
          end else if (cnt_r < last_s) begin
            mem_a_r    <= mem_a_r + 32'd1;
            mem_dout_r <= byte_of(ls_data_r, cnt_r[1:0] + 2'd1);
            cnt_r      <= cnt_r + 3'd1;
          end else begin
            mem_wr_r    <= 1'b0;
            lsb_valid_r <= 1'b1;
            state_r     <= IDLE;
            cnt_r       <= 3'd0;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_dout         = mem_dout_r;
  assign bus.mem_a            = mem_a_r;
  assign bus.mem_wr           = mem_wr_r;
  assign bus.IF_output_valid  = if_valid_r;
  assign bus.IF_inst          = if_inst_r;
  assign bus.LSB_output_valid = lsb_valid_r;
  assign bus.LSB_load_data    = lsb_data_r;

endmodule
